// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the frame state encoding, majority voting and parity reduction.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;

  localparam int MAX_DATA_BITS = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Loadable down-counter that emits a one-cycle sample tick every reload+1 clocks.
// While disabled it sits at the reload value so the first tick lands a full period later.
module uart_rx_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] reload,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!en || tick)
      cnt <= reload;
    else
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 3-sample majority voting, optional parity,
// one or two stop bits, and a valid/ready holding register with error and overrun flags.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);
  localparam logic [SC_W-1:0] SC_LO   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_HI   = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

  state_t               state, state_n;
  logic                 sync1, rxs;
  logic [SC_W-1:0]      sc;
  logic [BI_W-1:0]      bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 s_lo, s_mid;
  logic                 stop_second;
  logic                 perr_acc, ferr_acc, ferr_fin;
  logic [DIV_W-1:0]     div_q;
  logic                 tick, tick_en, resolve, bitv, done;
  logic [DIV_W-1:0]     reload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rxs   <= sync1;
    end
  end

  // Divisor is frozen at start detection so mid-frame changes cannot skew sampling.
  assign tick_en = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign reload  = (state == IDLE) ? baud_div : div_q;

  uart_rx_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (tick_en),
    .reload (reload),
    .tick   (tick)
  );

  assign resolve  = tick && (sc == SC_HI);
  assign bitv     = maj3(s_lo, s_mid, rxs);
  assign ferr_fin = ferr_acc | ~bitv;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE:    if (!rxs) state_n = START;
      START:   if (resolve) state_n = bitv ? IDLE : DATA;
      DATA:    if (resolve && bit_idx == BI_LAST) state_n = parity_en ? PARITY : STOP;
      PARITY:  if (resolve) state_n = STOP;
      STOP: begin
        if (resolve && !(two_stop && !stop_second)) begin
          done    = 1'b1;
          state_n = bitv ? IDLE : BRKWAIT;
        end
      end
      BRKWAIT: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc          <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      s_lo        <= 1'b0;
      s_mid       <= 1'b0;
      stop_second <= 1'b0;
      perr_acc    <= 1'b0;
      ferr_acc    <= 1'b0;
      div_q       <= '0;
    end else if (state == IDLE) begin
      sc          <= '0;
      bit_idx     <= '0;
      stop_second <= 1'b0;
      perr_acc    <= 1'b0;
      ferr_acc    <= 1'b0;
      if (!rxs) div_q <= baud_div;
    end else if (tick) begin
      sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
      if (sc == SC_LO)  s_lo  <= rxs;
      if (sc == SC_MID) s_mid <= rxs;
      if (resolve) begin
        case (state)
          DATA: begin
            shreg   <= {bitv, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          PARITY:  perr_acc <= parity_of(MAX_DATA_BITS'(shreg)) ^ bitv ^ parity_odd;
          STOP: begin
            ferr_acc    <= ferr_fin;
            stop_second <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Holding register: a frame lands only if the slot is empty or being drained this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (done && (!rx_valid || rx_ready)) begin
        rx_data       <= shreg;
        rx_parity_err <= perr_acc;
        rx_frame_err  <= ferr_fin;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (done && rx_valid && !rx_ready)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, successor to the fixed 8N1 receive state machine. It adds configurable data width, an optional parity bit, one or two stop bits, and 16x-class oversampling with 3-sample majority voting. It also adds an input synchronizer, glitch rejection on the start bit, and a valid/ready output holding register with parity, framing and overrun reporting. It sits between the pad-side serial input and the host bus/FIFO.

## Interface
- DATA_BITS, 8, data bits per frame, 5..9
- OVERSAMPLE, 16, sample ticks per bit, even, 8..32
- DIV_W, 16, width of baud divisor
- clk  in  1  clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- serial_in  in  1  asynchronous RX line, idle high
- baud_div  in  DIV_W  sample-tick period minus one (tick every baud_div+1 clocks)
- parity_en  in  1  1 = parity bit present after data
- parity_odd  in  1  1 = odd parity, 0 = even
- two_stop  in  1  1 = two stop bits checked
- rx_data  out  DATA_BITS  received word, LSB first on line
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready
- rx_parity_err  out  1  parity error for word in rx_data
- rx_frame_err  out  1  stop bit sampled low for word in rx_data
- overrun  out  1  sticky; frame lost because holding register full
- overrun_clr  in  1  clears overrun
- busy  out  1  state != IDLE

## Operation
- serial_in passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized bit `rxs`.
- Tick generator: counter reloads to baud_div and emits a 1-cycle `tick` at 0. It is held at reload in IDLE. baud_div is latched on start detection; changes mid-frame are ignored.
- Sample counter `sc` (0..OVERSAMPLE-1) advances on each tick. The bit value is the majority of rxs at sc = M-1, M, M+1, where M = OVERSAMPLE/2. The bit is resolved at sc = M+1.
- States:
  - IDLE: on rxs = 0 → START, sc = 0.
  - START: at resolve, majority 1 → IDLE (glitch, no output); majority 0 → DATA. At the end of the bit (sc wraps), the bit index resets to 0.
  - DATA: shift each resolved bit into the MSB of the shift register (LSB first). After DATA_BITS bits → PARITY if parity_en, else STOP.
  - PARITY: the resolved bit is XORed with the data XOR. Error = (xor ^ parity_odd) != 0, where xor includes the parity bit.
  - STOP: at resolve of the first stop bit, frame_err = !bit. With two_stop, the second bit is also checked and errors OR together. Frame completes at the final stop resolve; then → IDLE if bit = 1, else → BRKWAIT.
  - BRKWAIT: wait for rxs = 1, then → IDLE. This prevents false starts during a break.
- Completion:
  - If rx_valid = 0 or (rx_valid & rx_ready) in the same cycle, load rx_data and both error flags, and set rx_valid.
  - Otherwise discard the frame and set overrun.
- rx_valid clears on a handshake with no simultaneous completion.
- overrun_clr and overrun set in the same cycle: set wins.
- Reset (any time, including mid-frame): state IDLE. rx_data = 0, rx_valid = 0, rx_parity_err = 0, rx_frame_err = 0, overrun = 0, busy = 0, synchronizer = 1, counters = 0.

## Timing
- Bit period = OVERSAMPLE × (baud_div+1) clocks.
- Start edge to START entry: 2-cycle synchronizer latency plus 1 cycle.
- rx_valid rises the cycle after the final stop-bit resolve tick.
- Output registers change only on completion or handshake; no combinational path from rx_ready to rx_valid.
- Minimum supported baud_div is 0 (tick every clock).

## Structure
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BRKWAIT), majority-vote function, parity function.
- Sub-module uart_rx_tick: loadable down-counter tick generator with enable. Everything else lives in uart_rx_param.

## Test plan
- 8N1, baud_div = 0, OVERSAMPLE = 16: send 0xA5 → rx_data = 0xA5, rx_valid = 1, both error flags 0, rx_valid 1 cycle after the stop resolve.
- Glitch: line low for 4 clocks, then high → no rx_valid, busy returns to 0 within 1 bit time.
- 8E1 with the parity bit flipped on 0x03 → rx_data = 0x03, rx_parity_err = 1. 7O2 with second stop = 0 → rx_frame_err = 1, then BRKWAIT until the line goes high.
- Overrun: rx_ready = 0, send 0x11 then 0x22 → rx_data stays 0x11, overrun = 1. overrun_clr clears it. Handshake in the same cycle as completion of 0x33 → 0x33 loads, no overrun.
- Reset asserted mid-DATA → all outputs at reset values immediately. A subsequent frame 0x5A receives correctly.
- DATA_BITS = 9, baud_div = 3: send 0x1FF → rx_data = 0x1FF. baud_div changed mid-frame has no effect on that frame.
